// File: rtl/wb_pkg.sv
// Shared types and sizes for the write-back arbiter slice.
package wb_pkg;

  localparam int unsigned REG_ADDR_W       = 5;
  localparam int unsigned XLEN             = 32;
  localparam int unsigned LU_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with full/empty flags and active-low synchronous reset.
module wb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter + long-latency scoreboard; WB_LU_BUFFER_EN adds an LU_DEPTH result FIFO.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned LU_DEPTH = LU_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_wen,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic [XLEN-1:0]       ex_rd_data,
  input  logic                  lu_issue,
  input  logic [REG_ADDR_W-1:0] lu_issue_addr,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_rd_addr,
  input  logic [XLEN-1:0]       lu_rd_data,
  output logic                  lu_ready,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  output logic                  hazard_stall,
  output logic                  rd_wen,
  output logic [REG_ADDR_W-1:0] rd_forward_addr,
  output logic [XLEN-1:0]       rd_forward_data
);

  if (LU_DEPTH < 2 || (LU_DEPTH & (LU_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("LU_DEPTH must be a power of two >= 2");
  end

  logic        ex_sel;
  logic        lu_hs;
  logic        out_lu;
  wb_entry_t   lu_in;
  wb_entry_t   lu_out;
  logic [31:0] pending;
  logic [31:0] pending_next;

  assign ex_sel = ex_wen && (ex_rd_addr != '0);
  assign lu_hs  = lu_valid && lu_ready;
  assign lu_in  = '{addr: lu_rd_addr, data: lu_rd_data};

`ifdef WB_LU_BUFFER_EN
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       direct;
  logic [$bits(wb_entry_t)-1:0] fifo_head;

  // An accepted result with nothing older queued and no EX winner goes straight
  // to the output register, giving the one-cycle handshake-to-write latency.
  assign direct    = lu_hs && !ex_sel && fifo_empty;
  assign fifo_push = lu_hs && !direct;
  assign fifo_pop  = !ex_sel && !fifo_empty;
  assign lu_ready  = rst && !fifo_full;
  assign out_lu    = fifo_pop || direct;
  assign lu_out    = fifo_pop ? wb_entry_t'(fifo_head) : lu_in;

  wb_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (LU_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (lu_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
`else
  assign lu_ready = rst && !ex_sel;
  assign out_lu   = lu_hs;
  assign lu_out   = lu_in;
`endif

  // Clear on LU write-back first so a same-cycle issue to that register wins.
  always_comb begin
    pending_next = pending;
    if (out_lu) pending_next[lu_out.addr] = 1'b0;
    if (lu_issue && (lu_issue_addr != '0)) pending_next[lu_issue_addr] = 1'b1;
  end

  assign hazard_stall = rst && id_valid &&
                        (pending[id_rs1_addr] || pending[id_rs2_addr] || pending[id_rd_addr]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_wen          <= 1'b0;
      rd_forward_addr <= '0;
      rd_forward_data <= '0;
      pending         <= '0;
    end else begin
      rd_wen  <= 1'b0;
      pending <= pending_next;
      if (ex_sel) begin
        rd_wen          <= 1'b1;
        rd_forward_addr <= ex_rd_addr;
        rd_forward_data <= ex_rd_data;
      end else if (out_lu && (lu_out.addr != '0)) begin
        rd_wen          <= 1'b1;
        rd_forward_addr <= lu_out.addr;
        rd_forward_data <= lu_out.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + random bench for wb_arbiter against a queue-based write-back model.
module tb_wb_arbiter;

  localparam int unsigned TB_DEPTH = 2;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        ex_wen;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_rd_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_addr;
  logic        lu_valid;
  logic [4:0]  lu_rd_addr;
  logic [31:0] lu_rd_data;
  logic        lu_ready;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  id_rd_addr;
  logic        hazard_stall;
  logic        rd_wen;
  logic [4:0]  rd_forward_addr;
  logic [31:0] rd_forward_data;

  wb_arbiter #(.LU_DEPTH(TB_DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_wen          (ex_wen),
    .ex_rd_addr      (ex_rd_addr),
    .ex_rd_data      (ex_rd_data),
    .lu_issue        (lu_issue),
    .lu_issue_addr   (lu_issue_addr),
    .lu_valid        (lu_valid),
    .lu_rd_addr      (lu_rd_addr),
    .lu_rd_data      (lu_rd_data),
    .lu_ready        (lu_ready),
    .id_valid        (id_valid),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rd_addr      (id_rd_addr),
    .hazard_stall    (hazard_stall),
    .rd_wen          (rd_wen),
    .rd_forward_addr (rd_forward_addr),
    .rd_forward_data (rd_forward_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  ent_t q[$];
  bit [31:0] pend;
  bit        m_wen;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  bit        last_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_wen = 0; ex_rd_addr = 0; ex_rd_data = 0;
    lu_issue = 0; lu_issue_addr = 0;
    lu_valid = 0; lu_rd_addr = 0; lu_rd_data = 0;
    id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic cycle();
    bit   ex_sel;
    bit   m_ready;
    bit   m_stall;
    ent_t ent;
    #1;
    ex_sel = ex_wen && (ex_rd_addr != 0);
    if (!rst) begin
      m_ready = 0;
      m_stall = 0;
    end else begin
`ifdef WB_LU_BUFFER_EN
      m_ready = (q.size() < TB_DEPTH);
`else
      m_ready = !ex_sel;
`endif
      m_stall = id_valid && (pend[id_rs1_addr] || pend[id_rs2_addr] || pend[id_rd_addr]);
    end
    last_ready = m_ready;
    chk("lu_ready", lu_ready, m_ready);
    chk("hazard_stall", hazard_stall, m_stall);

    if (!rst) begin
      q.delete();
      pend = 0; m_wen = 0; m_addr = 0; m_data = 0;
    end else begin
      if (lu_valid && m_ready) q.push_back('{addr: lu_rd_addr, data: lu_rd_data});
      m_wen = 0;
      if (ex_sel) begin
        m_wen = 1; m_addr = ex_rd_addr; m_data = ex_rd_data;
      end else if (q.size() > 0) begin
        ent = q.pop_front();
        pend[ent.addr] = 0;
        if (ent.addr != 0) begin
          m_wen = 1; m_addr = ent.addr; m_data = ent.data;
        end
      end
      if (lu_issue && lu_issue_addr != 0) pend[lu_issue_addr] = 1;
    end

    @(posedge clk);
    #1;
    chk("rd_wen", rd_wen, m_wen);
    chk("rd_forward_addr", rd_forward_addr, m_addr);
    chk("rd_forward_data", rd_forward_data, m_data);
  endtask

  initial begin
    int acc;
    idle();
    rst = 0;
    cycle(); cycle();
    chk("reset_wen", rd_wen, 0);
    chk("reset_addr", rd_forward_addr, 0);
    chk("reset_data", rd_forward_data, 0);
    rst = 1;
    cycle();

    // EX only
    ex_wen = 1; ex_rd_addr = 5; ex_rd_data = 32'h1234;
    cycle();
    chk("ex_only_wen", rd_wen, 1);
    chk("ex_only_addr", rd_forward_addr, 5);
    chk("ex_only_data", rd_forward_data, 32'h1234);
    idle();
    cycle();
    chk("ex_only_one_cycle", rd_wen, 0);

    // x0 writes
    ex_wen = 1; ex_rd_addr = 0; ex_rd_data = 32'hFFFF;
    cycle();
    chk("ex_x0_wen", rd_wen, 0);
    idle();
    lu_valid = 1; lu_rd_addr = 0; lu_rd_data = 32'h5555;
    cycle();
    chk("lu_x0_accepted", last_ready, 1);
    chk("lu_x0_wen", rd_wen, 0);
    idle();
    cycle();
    chk("lu_x0_no_late_wen", rd_wen, 0);

    // Scoreboard
    lu_issue = 1; lu_issue_addr = 7;
    id_valid = 1; id_rs2_addr = 7;
    cycle();
    chk("sb_stall_set", hazard_stall, 1);
    lu_issue = 0; lu_issue_addr = 0;
    lu_valid = 1; lu_rd_addr = 7; lu_rd_data = 32'hDEAD;
    cycle();
    chk("sb_wb_wen", rd_wen, 1);
    chk("sb_wb_data", rd_forward_data, 32'hDEAD);
    chk("sb_stall_drop", hazard_stall, 0);
    idle();
    cycle();

    // Contention: EX first, LU next cycle
    ex_wen = 1; ex_rd_addr = 3; ex_rd_data = 32'h33;
    lu_valid = 1; lu_rd_addr = 9; lu_rd_data = 32'h99;
    cycle();
    chk("cont_ex_addr", rd_forward_addr, 3);
`ifndef WB_LU_BUFFER_EN
    chk("cont_ready_low", last_ready, 0);
`endif
    ex_wen = 0; ex_rd_addr = 0; ex_rd_data = 0;
`ifdef WB_LU_BUFFER_EN
    lu_valid = 0; lu_rd_addr = 0; lu_rd_data = 0;
`endif
    cycle();
    chk("cont_lu_wen", rd_wen, 1);
    chk("cont_lu_addr", rd_forward_addr, 9);
    idle();
    cycle();

    // Back-pressure under continuous EX writes
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      ex_wen = 1; ex_rd_addr = 5'(10 + i); ex_rd_data = 32'hE0 + 32'(i);
      lu_valid = (acc < 3); lu_rd_addr = 5'(20 + acc); lu_rd_data = 32'h100 + 32'(acc);
      cycle();
      if (lu_valid && last_ready) acc++;
    end
`ifdef WB_LU_BUFFER_EN
    chk("bp_accepted", acc, TB_DEPTH);
`else
    chk("bp_accepted", acc, 0);
`endif
    idle();
    for (int i = 0; i < 4; i++) cycle();

    // Set/clear collision on x4
    lu_issue = 1; lu_issue_addr = 4;
    cycle();
    lu_valid = 1; lu_rd_addr = 4; lu_rd_data = 32'h44;
    cycle();
    chk("coll_wb_addr", rd_forward_addr, 4);
    idle();
    id_valid = 1; id_rd_addr = 4;
    #1;
    chk("coll_pending_kept", hazard_stall, 1);
    cycle();
    lu_valid = 1; lu_rd_addr = 4; lu_rd_data = 32'h45;
    cycle();
    chk("coll_cleared", hazard_stall, 0);
    idle();
    cycle();

    // Reset mid-operation
    lu_issue = 1; lu_issue_addr = 4;
    cycle();
    lu_issue_addr = 7;
    cycle();
    lu_issue = 0; lu_issue_addr = 0;
    ex_wen = 1; ex_rd_addr = 12; ex_rd_data = 32'hC;
    lu_valid = 1; lu_rd_addr = 4; lu_rd_data = 32'hA4;
    cycle();
    ex_rd_addr = 13; ex_rd_data = 32'hD;
    lu_rd_addr = 7; lu_rd_data = 32'hA7;
    cycle();
    idle();
    id_valid = 1; id_rs1_addr = 4; id_rs2_addr = 7;
    rst = 0;
    cycle();
    chk("rst_mid_wen", rd_wen, 0);
    chk("rst_mid_stall", hazard_stall, 0);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_no_stale_wen", rd_wen, 0);
      chk("rst_no_stale_stall", hazard_stall, 0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 59) != 0);
      ex_wen        = ($urandom_range(0, 9) < 4);
      ex_rd_addr    = 5'($urandom_range(0, 7));
      ex_rd_data    = $urandom;
      lu_issue      = ($urandom_range(0, 9) < 3);
      lu_issue_addr = 5'($urandom_range(0, 7));
      lu_valid      = ($urandom_range(0, 9) < 4);
      lu_rd_addr    = 5'($urandom_range(0, 7));
      lu_rd_data    = $urandom;
      id_valid      = ($urandom_range(0, 9) < 7);
      id_rs1_addr   = 5'($urandom_range(0, 7));
      id_rs2_addr   = 5'($urandom_range(0, 7));
      id_rd_addr    = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and long-latency scoreboard sitting between the execute stage / multi-cycle unit and the register-file write port. Merges single-cycle EX results with results from a long-latency unit (divider or load path) into one registered write stream (`rd_wen`/`rd_forward_addr`/`rd_forward_data`) feeding the register file. Tracks registers with outstanding long-latency writes and raises a stall toward ID so that no RAW or WAW hazard reaches the register file.

## Interface
Parameters:
- `LU_DEPTH`, 2: long-latency result buffer entries (power of two, ≥2).

Ports:
- `clk`  in  1  single clock, all state on posedge.
- `rst`  in  1  reset, synchronous, active-low.
- `ex_wen`  in  1  EX result valid this cycle.
- `ex_rd_addr`  in  5  EX destination register.
- `ex_rd_data`  in  32  EX result.
- `lu_issue`  in  1  ID issues a long-latency op this cycle.
- `lu_issue_addr`  in  5  its destination register.
- `lu_valid`  in  1  long-latency result offered.
- `lu_rd_addr`  in  5  long-latency destination.
- `lu_rd_data`  in  32  long-latency result.
- `lu_ready`  out  1  result accepted when `lu_valid && lu_ready`.
- `id_valid`  in  1  ID holds a valid instruction.
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr`  in  5 each  ID operand/destination addresses.
- `hazard_stall`  out  1  ID must hold.
- `rd_wen`  out  1  register-file write enable.
- `rd_forward_addr`  out  5  write address.
- `rd_forward_data`  out  32  write data.

## Operation
- Write select each cycle: EX has fixed priority. If `ex_wen && ex_rd_addr!=0`, EX is written. Otherwise the oldest buffer entry is popped and written. If the buffer is empty, no write occurs.
- Writes to x0 are dropped: `rd_wen` stays 0. An LU entry addressed to x0 is still popped and consumed.
- Buffer: FIFO of {addr, data}. It is pushed on `lu_valid && lu_ready`, and `lu_ready = !full`. A push and a pop may occur in the same cycle. When the buffer is full and a pop occurs in the same cycle, `lu_ready` stays 0; it is not bypassed.
- Scoreboard: 32 pending bits.
  - `lu_issue` with `lu_issue_addr!=0` sets `pending[lu_issue_addr]`.
  - The bit clears on the edge where the matching LU entry is loaded into the output register.
  - If set and clear hit the same address in the same cycle, set wins.
- `hazard_stall = id_valid && (pending[id_rs1_addr] | pending[id_rs2_addr] | pending[id_rd_addr])`. This is combinational. `pending[0]` is always 0.
- Upstream must not assert `lu_issue` or `ex_wen` for an instruction while `hazard_stall` is high. Consequently EX never targets a pending register.

## Timing
- Output register: the selected write appears on `rd_wen`/`rd_forward_addr`/`rd_forward_data` one cycle after the EX or pop cycle, and is held for exactly one cycle.
- The register file forwards combinationally in that cycle. In the cycle after the pending bit clears, ID sees `hazard_stall=0` and reads the forwarded value.
- End-to-end latency with an empty buffer and no EX conflict: LU handshake at cycle N → `rd_wen=1` at N+1 → stall drops at N+1.
- Reset (`rst==0` at posedge): `rd_wen=0`, `rd_forward_addr=0`, `rd_forward_data=0`, buffer empty, all pending bits cleared.
  - `lu_ready=0` and `hazard_stall=0` while `rst==0`.
  - Reset mid-operation discards buffered results and in-flight scoreboard state.

## Configuration
- `WB_LU_BUFFER_EN` defined: the FIFO of `LU_DEPTH` entries exists as described.
- `WB_LU_BUFFER_EN` undefined:
  - No storage; `lu_ready = !(ex_wen && ex_rd_addr!=0)`.
  - An accepted LU result is written directly through the output register.
  - The scoreboard is unchanged.

## Structure
- Shared package `wb_pkg`: `REG_ADDR_W=5`, `XLEN=32`, `LU_DEPTH` default, and the `wb_entry_t` {addr, data} struct.
- One sub-module: `wb_fifo`, a generic synchronous FIFO (push/pop/full/empty, active-low sync reset). It is instantiated only under `WB_LU_BUFFER_EN`.

## Test plan
- **EX only:** `ex_wen=1`, addr 5, data 0x1234 at cycle N → `rd_wen=1`, addr 5, data 0x1234 at N+1 only.
- **x0 writes:** `ex_wen=1`, addr 0 → `rd_wen` stays 0. LU result to x0 is accepted and produces no write.
- **Scoreboard:**
  - `lu_issue` addr 7, then `id_rs2_addr=7` with `id_valid=1` → `hazard_stall=1`.
  - LU result addr 7, data 0xDEAD → write at next cycle; stall low that cycle; ID reads 0xDEAD.
- **Contention:**
  - `ex_wen` (addr 3) and LU valid (addr 9) in the same cycle → EX written first, LU written the following cycle.
  - Three back-to-back LU results under continuous EX writes → `lu_ready` drops after 2 accepted (`LU_DEPTH=2`).
  - With `WB_LU_BUFFER_EN` undefined → `lu_ready=0` whenever EX writes.
- **Set/clear collision:** LU write of addr 4 pops in the same cycle as `lu_issue` to addr 4 → `pending[4]` remains 1.
- **Reset mid-operation:** assert `rst=0` with buffer holding 2 entries and pending {4,7} → next cycle `rd_wen=0`, `hazard_stall=0`, buffer empty, no stale write after release.
